// File: rtl/ft64_ret_stack.sv
// ft64_ret_stack: circular return-address stack with overflow/underflow
// pulses and checkpoint restore for branch-miss recovery.
module ft64_ret_stack #(
  parameter int AMSB  = 31,
  parameter int DEPTH = 16,
  parameter int PTRW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [AMSB:0]   push_pc,
  input  logic            pop,
  input  logic            restore,
  input  logic [PTRW-1:0] restore_sp,
  input  logic [PTRW:0]   restore_cnt,
  output logic [PTRW-1:0] sp_o,
  output logic [PTRW:0]   cnt_o,
  output logic [AMSB:0]   ret_addr,
  output logic            ret_valid,
  output logic            empty,
  output logic            full,
  output logic            ovf,
  output logic            udf
);

  localparam logic [PTRW:0] DEPTH_C = (PTRW+1)'(DEPTH);

  logic [AMSB:0]   mem [DEPTH];
  logic [PTRW-1:0] sp, sp_n, sp_inc, waddr;
  logic [PTRW:0]   cnt, cnt_n;
  logic            ovf_n, udf_n, we;

  assign sp_inc    = sp + PTRW'(1);
  assign sp_o      = sp;
  assign cnt_o     = cnt;
  assign empty     = (cnt == '0);
  assign full      = (cnt == DEPTH_C);
  assign ret_valid = !empty;
  assign ret_addr  = empty ? '0 : mem[sp];

  // Next-state decode: restore beats push+pop beats push beats pop.
  always_comb begin
    sp_n  = sp;
    cnt_n = cnt;
    ovf_n = 1'b0;
    udf_n = 1'b0;
    we    = 1'b0;
    waddr = sp_inc;
    if (restore) begin
      sp_n  = restore_sp;
      cnt_n = (restore_cnt > DEPTH_C) ? DEPTH_C : restore_cnt;
    end else if (push && pop) begin
      we = 1'b1;
      if (!empty) begin
        // Top replaced in place: a RET followed by a CALL at the same level.
        waddr = sp;
      end else begin
        sp_n  = sp_inc;
        cnt_n = (PTRW+1)'(1);
        udf_n = 1'b1;
      end
    end else if (push) begin
      // When full, sp+1 lands on the oldest entry, so it is silently lost.
      we   = 1'b1;
      sp_n = sp_inc;
      if (full) ovf_n = 1'b1;
      else      cnt_n = cnt + (PTRW+1)'(1);
    end else if (pop) begin
      if (!empty) begin
        sp_n  = sp - PTRW'(1);
        cnt_n = cnt - (PTRW+1)'(1);
      end else begin
        udf_n = 1'b1;
      end
    end
  end

  // Pointer, count and event pulses; reset leaves sp one below entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= PTRW'(DEPTH - 1);
      cnt <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      sp  <= sp_n;
      cnt <= cnt_n;
      ovf <= ovf_n;
      udf <= udf_n;
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && we) mem[waddr] <= push_pc;
  end

endmodule

// File: tb/tb_ft64_ret_stack.sv
// tb_ft64_ret_stack: scoreboard bench for the return-address stack.
module tb_ft64_ret_stack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0, pop = 1'b0, restore = 1'b0;
  logic [31:0] push_pc = '0;
  logic [3:0]  restore_sp = '0;
  logic [4:0]  restore_cnt = '0;
  logic [3:0]  sp_o;
  logic [4:0]  cnt_o;
  logic [31:0] ret_addr;
  logic        ret_valid, empty, full, ovf, udf;

  ft64_ret_stack #(.AMSB(31), .DEPTH(16), .PTRW(4)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_pc(push_pc), .pop(pop),
    .restore(restore), .restore_sp(restore_sp), .restore_cnt(restore_cnt),
    .sp_o(sp_o), .cnt_o(cnt_o), .ret_addr(ret_addr), .ret_valid(ret_valid),
    .empty(empty), .full(full), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ra;
    logic        rv;
    logic [4:0]  cnt;
    logic [3:0]  sp;
    logic        ovf, udf, empty, full;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: plain LIFO over a 16-entry ring.
  logic [31:0] m_mem [16];
  int          m_sp  = 15;
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, queue the model's expectation, compare after the edge.
  task automatic step(input logic pu, input logic po, input logic rs,
                      input logic [31:0] pc, input logic [3:0] rsp, input logic [4:0] rcnt);
    exp_t e;
    logic eo, eu;
    @(negedge clk);
    push = pu; pop = po; restore = rs; push_pc = pc;
    restore_sp = rsp; restore_cnt = rcnt;
    eo = 1'b0; eu = 1'b0;
    if (rs) begin
      m_sp  = int'(rsp);
      m_cnt = (int'(rcnt) > 16) ? 16 : int'(rcnt);
    end else if (pu && po) begin
      if (m_cnt != 0) m_mem[m_sp] = pc;
      else begin
        m_sp = (m_sp + 1) % 16; m_mem[m_sp] = pc; m_cnt = 1; eu = 1'b1;
      end
    end else if (pu) begin
      m_sp = (m_sp + 1) % 16; m_mem[m_sp] = pc;
      if (m_cnt == 16) eo = 1'b1; else m_cnt++;
    end else if (po) begin
      if (m_cnt != 0) begin m_sp = (m_sp + 15) % 16; m_cnt--; end
      else eu = 1'b1;
    end
    e.ra = (m_cnt != 0) ? m_mem[m_sp] : 32'h0;
    e.rv = (m_cnt != 0);
    e.cnt = 5'(m_cnt);
    e.sp = 4'(m_sp);
    e.ovf = eo; e.udf = eu;
    e.empty = (m_cnt == 0); e.full = (m_cnt == 16);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_ra", ret_addr, e.ra);
    chk("sb_rv", ret_valid, e.rv);
    chk("sb_cnt", cnt_o, e.cnt);
    chk("sb_sp", sp_o, e.sp);
    chk("sb_ovf", ovf, e.ovf);
    chk("sb_udf", udf, e.udf);
    chk("sb_empty", empty, e.empty);
    chk("sb_full", full, e.full);
    push = 1'b0; pop = 1'b0; restore = 1'b0;
  endtask

  task automatic do_push(input logic [31:0] pc); step(1'b1, 1'b0, 1'b0, pc, 4'd0, 5'd0); endtask
  task automatic do_pop();                        step(1'b0, 1'b1, 1'b0, 32'h0, 4'd0, 5'd0); endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_sp", sp_o, 4'd15);
    chk("rst_cnt", cnt_o, 5'd0);
    chk("rst_ra", ret_addr, 32'h0);
    chk("rst_rv", ret_valid, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_udf", udf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_sp = 15; m_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] cp_sp;
    logic [4:0] cp_cnt;
    do_reset();

    // Basic LIFO order; first push lands in entry 0.
    do_push(32'h1000);
    chk("first_sp", sp_o, 4'd0);
    do_push(32'h2000);
    do_push(32'h3000);
    chk("b_ra", ret_addr, 32'h3000);
    chk("b_cnt", cnt_o, 5'd3);
    chk("b_sp", sp_o, 4'd2);
    do_pop(); chk("b_pop1", ret_addr, 32'h2000);
    do_pop(); chk("b_pop2", ret_addr, 32'h1000);
    do_pop(); chk("b_pop3_empty", empty, 1'b1); chk("b_pop3_ra", ret_addr, 32'h0);

    // Overflow: 17 pushes into a 16-deep stack.
    do_reset();
    for (int i = 1; i <= 17; i++) do_push(32'(i * 32'h100));
    chk("o_ovf", ovf, 1'b1);
    chk("o_cnt", cnt_o, 5'd16);
    chk("o_sp", sp_o, 4'd0);
    chk("o_ra", ret_addr, 32'h1100);
    for (int i = 17; i >= 2; i--) begin
      chk("o_top", ret_addr, 32'(i * 32'h100));
      do_pop();
    end
    chk("o_drained", ret_valid, 1'b0);
    do_pop();
    chk("o_udf", udf, 1'b1);

    // Underflow and push+pop on an empty stack.
    do_reset();
    do_pop();
    chk("u_udf", udf, 1'b1); chk("u_sp", sp_o, 4'd15); chk("u_cnt", cnt_o, 5'd0);
    step(1'b1, 1'b1, 1'b0, 32'hABC, 4'd0, 5'd0);
    chk("u_pp_udf", udf, 1'b1); chk("u_pp_cnt", cnt_o, 5'd1); chk("u_pp_ra", ret_addr, 32'hABC);
    do_pop();
    chk("u_pulse_clr", udf, 1'b0);

    // Replace-top, then checkpoint / restore.
    do_reset();
    do_push(32'h10); do_push(32'h20);
    step(1'b1, 1'b1, 1'b0, 32'h30, 4'd0, 5'd0);
    chk("r_cnt", cnt_o, 5'd2); chk("r_ra", ret_addr, 32'h30);
    do_pop(); chk("r_pop", ret_addr, 32'h10);
    do_push(32'h20);
    cp_sp = sp_o; cp_cnt = cnt_o;
    chk("cp_sp", cp_sp, 4'd1); chk("cp_cnt", cp_cnt, 5'd2);
    do_push(32'h40); do_push(32'h50);
    chk("cp_top", ret_addr, 32'h50);
    step(1'b1, 1'b0, 1'b1, 32'h99, cp_sp, cp_cnt);
    chk("rs_sp", sp_o, 4'd1); chk("rs_cnt", cnt_o, 5'd2); chk("rs_ra", ret_addr, 32'h20);
    step(1'b0, 1'b0, 1'b1, 32'h0, 4'd1, 5'd31);
    chk("rs_clamp_cnt", cnt_o, 5'd16); chk("rs_clamp_full", full, 1'b1);

    // Asynchronous reset in the middle of a push burst.
    do_reset();
    @(negedge clk);
    push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_pc = 32'h7000 + 32'(i);
      @(posedge clk);
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("a_sp", sp_o, 4'd15);
    chk("a_cnt", cnt_o, 5'd0);
    chk("a_rv", ret_valid, 1'b0);
    chk("a_ra", ret_addr, 32'h0);
    chk("a_ovf", ovf, 1'b0);
    chk("a_udf", udf, 1'b0);
    @(posedge clk); #1;
    chk("a_hold_cnt", cnt_o, 5'd0);
    chk("a_hold_ovf", ovf, 1'b0);
    chk("a_hold_udf", udf, 1'b0);
    @(negedge clk);
    push = 1'b0;
    rst_n = 1'b1;
    m_sp = 15; m_cnt = 0;
    do_push(32'h5555);
    chk("a_after_sp", sp_o, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ft64_ret_stack.md
FT64_RET_STACK -- requirements
Module: ft64_ret_stack

Interface
REQ-001 SHALL have parameter AMSB, default 31, MSB of the return-address width, matching the FCU address width.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, at least 4.
REQ-003 SHALL have parameter PTRW, default 4, equal to log2(DEPTH).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port push  input  1  committed CALL/JAL with link; capture the link address.
REQ-007 SHALL have port push_pc  input  AMSB+1  link address (the nextpc the FCU places on its bus for CALL/JAL).
REQ-008 SHALL have port pop  input  1  RET consumed; discard the top entry.
REQ-009 SHALL have port restore  input  1  branch-miss recovery; reload the pointer and count from a checkpoint.
REQ-010 SHALL have port restore_sp  input  PTRW  checkpointed stack pointer.
REQ-011 SHALL have port restore_cnt  input  PTRW+1  checkpointed entry count.
REQ-012 SHALL have port sp_o  output  PTRW  current stack pointer, for checkpointing.
REQ-013 SHALL have port cnt_o  output  PTRW+1  current valid-entry count.
REQ-014 SHALL have port ret_addr  output  AMSB+1  predicted RET target.
REQ-015 SHALL have port ret_valid  output  1  ret_addr holds a valid entry.
REQ-016 SHALL have ports empty and full  output  1 each  cnt==0 and cnt==DEPTH respectively.
REQ-017 SHALL have ports ovf and udf  output  1 each  registered one-cycle overflow and underflow pulses.

Function
REQ-018 Storage SHALL be a circular array of DEPTH entries, each AMSB+1 bits wide, with no reset on the array.
REQ-019 sp SHALL index the top entry; all pointer arithmetic SHALL be modulo DEPTH and wrap silently.
REQ-020 ret_addr SHALL be combinational: mem[sp] when cnt!=0, else all zeros; ret_valid = (cnt!=0).
REQ-021 Priority each cycle SHALL be: restore, then push-and-pop, then push, then pop.
REQ-022 On restore: sp<=restore_sp, cnt<=min(restore_cnt, DEPTH), array unchanged, push and pop ignored that cycle.
REQ-023 On push only: sp<=sp+1, mem[sp+1]<=push_pc, cnt<=cnt+1.
REQ-024 On push only with cnt==DEPTH: the oldest entry is overwritten, cnt stays DEPTH, ovf=1 the next cycle.
REQ-025 On pop only with cnt!=0: sp<=sp-1, cnt<=cnt-1, array unchanged.
REQ-026 On pop only with cnt==0: sp and cnt unchanged, udf=1 the next cycle.
REQ-027 On push and pop with cnt!=0: mem[sp]<=push_pc (top replaced), sp and cnt unchanged.
REQ-028 On push and pop with cnt==0: behave as push only (sp+1, cnt=1), udf=1 the next cycle.
REQ-029 ovf and udf SHALL each be high for exactly one cycle per event, otherwise low.
REQ-030 A value pushed in cycle N SHALL appear on ret_addr in cycle N+1 (one-cycle latency).
REQ-031 No valid/ready handshake: push and pop are single-cycle strobes and are always accepted.

Reset
REQ-032 While rst_n=0: sp=DEPTH-1, cnt=0, ovf=0, udf=0; hence ret_addr=0, ret_valid=0, empty=1, full=0.
REQ-033 Reset asserted mid-operation SHALL abandon all state immediately; array contents are don't-care afterwards.
REQ-034 The first push after reset SHALL write entry 0.

Verification
REQ-035 Reset, then push 0x1000, 0x2000, 0x3000 -> ret_addr=0x3000, cnt_o=3, sp_o=2; pop -> 0x2000; pop -> 0x1000; pop -> empty=1, ret_addr=0.
REQ-036 DEPTH=16: push 0x100..0x1100 (17 values, step 0x100) -> the 17th push gives ovf pulse, cnt_o=16, sp_o=0, ret_addr=0x1100; 16 pops return 0x1100 down to 0x200, and no further valid entry remains.
REQ-037 Empty stack: pop -> udf pulse, sp_o=15, cnt_o=0; push and pop together with 0xABC -> udf pulse, cnt_o=1, ret_addr=0xABC.
REQ-038 Stack [0x10, 0x20]: push and pop together with 0x30 -> cnt_o=2, ret_addr=0x30; pop -> ret_addr=0x10.
REQ-039 Checkpoint sp_o=1 and cnt_o=2; push 0x40, 0x50; then restore with push asserted -> sp_o=1, cnt_o=2, ret_addr=the pre-checkpoint top, push ignored.
REQ-040 Drive rst_n low asynchronously between clock edges during a push burst -> outputs reach their reset values before the next clock edge, with no ovf or udf pulse.
